// File: rtl/fb_read_addr.sv
// Frame-buffer read address generator.
// Walks a stored IMG_W x IMG_H image in raster order, one displayed pixel per
// pix_en, producing rd_addr = line_base + column with no added latency.
// Optional macro SCALE2X_EN: 2x upscaling, where each stored pixel is shown
// twice horizontally and each stored row twice vertically.
// Without SCALE2X_EN the mapping is 1:1 and no phase registers exist.
module fb_read_addr #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int n     = 17
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         frame_start,
    input  logic         pix_en,
    output logic [n-1:0] rd_addr,
    output logic         rd_en,
    output logic         line_done,
    output logic         frame_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [n-1:0] LAST_COL = n'(IMG_W - 1);
    localparam logic [n-1:0] LAST_ROW = n'(IMG_H - 1);
    localparam logic [n-1:0] ROW_STEP = n'(IMG_W);

    state_t       state;
    logic [n-1:0] line_base;
    logic [n-1:0] column;
    logic [n-1:0] row;

    // advance: a displayed pixel is consumed this edge (frame_start wins).
    // pixel_step: the consumed pixel moves to the next stored column.
    // line_step: the finished displayed line moves to the next stored row.
    logic advance;
    logic pixel_step;
    logic line_step;

`ifdef SCALE2X_EN
    logic h_phase;
    logic v_phase;

    // Second repeat of a pixel / row is the one that actually steps.
    always_comb begin
        pixel_step = h_phase;
        line_step  = v_phase;
    end
`else
    // Every consumed pixel and every finished line steps the stored image.
    always_comb begin
        pixel_step = 1'b1;
        line_step  = 1'b1;
    end
`endif

    // Consumption qualifier and combinational outputs.
    always_comb begin
        advance = (state == ACTIVE) && pix_en && !frame_start;
        rd_en   = reset && pix_en && (state == ACTIVE);
        rd_addr = line_base + column;
    end

    // Sequencer: state, raster counters, scale phases and registered pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            line_base  <= '0;
            column     <= '0;
            row        <= '0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
`ifdef SCALE2X_EN
            h_phase    <= 1'b0;
            v_phase    <= 1'b0;
`endif
        end else begin
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            if (frame_start) begin
                // A new frame restarts from the top-left from any state.
                state     <= ACTIVE;
                line_base <= '0;
                column    <= '0;
                row       <= '0;
`ifdef SCALE2X_EN
                h_phase   <= 1'b0;
                v_phase   <= 1'b0;
`endif
            end else if (advance) begin
`ifdef SCALE2X_EN
                h_phase <= ~h_phase;
`endif
                if (pixel_step) begin
                    if (column == LAST_COL) begin
                        // End of a displayed line: rewind column either way.
                        column    <= '0;
                        line_done <= 1'b1;
`ifdef SCALE2X_EN
                        v_phase   <= ~v_phase;
`endif
                        if (line_step) begin
                            if (row == LAST_ROW) begin
                                // Last pixel of the frame: park at address 0.
                                row        <= '0;
                                line_base  <= '0;
                                frame_done <= 1'b1;
                                state      <= DONE;
                            end else begin
                                row       <= row + 1'b1;
                                line_base <= line_base + ROW_STEP;
                            end
                        end
                    end else begin
                        column <= column + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_read_addr.sv
// Self-checking bench for fb_read_addr (IMG_W=4, IMG_H=3).
// The reference model tracks only the number of pixels consumed in the
// current frame and derives address and pulses from it arithmetically.
module tb_fb_read_addr;

    localparam int IMG_W = 4;
    localparam int IMG_H = 3;
    localparam int N     = 4;
`ifdef SCALE2X_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif
    localparam int LINE  = IMG_W * S;
    localparam int TOTAL = LINE * IMG_H * S;

    localparam int M_IDLE   = 0;
    localparam int M_ACTIVE = 1;
    localparam int M_DONE   = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         frame_start = 1'b0;
    logic         pix_en = 1'b0;
    logic [N-1:0] rd_addr;
    logic         rd_en;
    logic         line_done;
    logic         frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_state = M_IDLE;
    int k       = 0;
    bit m_ld    = 1'b0;
    bit m_fd    = 1'b0;

    fb_read_addr #(.IMG_W(IMG_W), .IMG_H(IMG_H), .n(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .pix_en     (pix_en),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .line_done  (line_done),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Expected address: displayed line/column from k, then divide by scale.
    function automatic int exp_addr();
        if (m_state != M_ACTIVE) return 0;
        return ((k / LINE) / S) * IMG_W + (k % LINE) / S;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, then
    // step the model on the rising edge and check registered results.
    task automatic cycle(input bit fs, input bit pe);
        @(negedge clk);
        frame_start = fs;
        pix_en      = pe;
        #1;
        chk("rd_en", 32'(rd_en), 32'(pe && (m_state == M_ACTIVE)));
        chk("rd_addr_pre", 32'(rd_addr), 32'(exp_addr()));
        @(posedge clk);
        #1;
        m_ld = 1'b0;
        m_fd = 1'b0;
        if (fs) begin
            m_state = M_ACTIVE;
            k       = 0;
        end else if (m_state == M_ACTIVE && pe) begin
            if ((k + 1) % LINE == 0) m_ld = 1'b1;
            if (k + 1 == TOTAL) begin
                m_fd    = 1'b1;
                m_state = M_DONE;
                k       = 0;
            end else begin
                k = k + 1;
            end
        end
        chk("line_done", 32'(line_done), 32'(m_ld));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("rd_addr_post", 32'(rd_addr), 32'(exp_addr()));
    endtask

    initial begin
        int guard;

        // Reset state, with pix_en high to show rd_en is held low
        pix_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_line_done", 32'(line_done), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // pix_en in IDLE is ignored
        repeat (3) cycle(1'b0, 1'b1);

        // Full frame, continuous pix_en
        cycle(1'b1, 1'b0);
        repeat (TOTAL) cycle(1'b0, 1'b1);
        chk("cont_done_state", 32'(m_state), 32'(M_DONE));

        // pix_en in DONE is ignored
        repeat (3) cycle(1'b0, 1'b1);

        // Full frame, gapped pix_en (1 high, 2 low)
        cycle(1'b1, 1'b0);
        for (int i = 0; i < TOTAL; i++) begin
            cycle(1'b0, 1'b1);
            cycle(1'b0, 1'b0);
            cycle(1'b0, 1'b0);
        end

        // frame_start at pixel 5 together with pix_en restarts the frame
        cycle(1'b1, 1'b0);
        guard = 0;
        while (k != 5 && guard < 200) begin
            cycle(1'b0, 1'($urandom_range(0, 1)));
            guard++;
        end
        chk("restart_reach", 32'(k), 32'd5);
        cycle(1'b1, 1'b1);
        chk("restart_addr0", 32'(rd_addr), 32'd0);
        repeat (TOTAL) cycle(1'b0, 1'b1);
        chk("restart_done_state", 32'(m_state), 32'(M_DONE));

        // Asynchronous reset mid-frame at rd_addr=6
        cycle(1'b1, 1'b0);
        guard = 0;
        while (exp_addr() != 6 && guard < 200) begin
            cycle(1'b0, 1'($urandom_range(0, 1)));
            guard++;
        end
        chk("mid_addr6", 32'(rd_addr), 32'd6);
        @(negedge clk);
        frame_start = 1'b0;
        pix_en      = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        m_state = M_IDLE;
        k       = 0;
        m_ld    = 1'b0;
        m_fd    = 1'b0;
        chk("async_rd_addr", 32'(rd_addr), 32'd0);
        chk("async_rd_en", 32'(rd_en), 32'd0);
        chk("async_line_done", 32'(line_done), 32'd0);
        @(posedge clk);
        #1;
        chk("async_hold_addr", 32'(rd_addr), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) cycle(1'b0, 1'b1);

        // Randomized pix_en over a whole frame with a cycle budget
        cycle(1'b1, 1'($urandom_range(0, 1)));
        guard = 0;
        while (m_state == M_ACTIVE && guard < 2000) begin
            cycle(1'b0, 1'($urandom_range(0, 1)));
            guard++;
        end
        chk("random_frame_done", 32'(m_state), 32'(M_DONE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
